// File: rtl/fork_sync_pkg.sv
// Shared types and helpers for the four-phase handshake blocks.
package async_hs_pkg;

  typedef enum logic [1:0] {HS_IDLE, HS_RISE, HS_ACK, HS_FALL} hs_state_t;

  // Timeout counter width is $clog2(TIMEOUT+1); kept at 1 bit when the timeout is off.
  function automatic int hs_to_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fork_sync_if.sv
// Handshake bundle of the fork: one upstream channel, two downstream branches.
interface fork_sync_if;
  logic r_i;
  logic a_i;
  logic r_o;
  logic a_o;
  logic r1_o;
  logic a1_o;

  modport master (input r_i, a_o, a1_o, output a_i, r_o, r1_o);
  modport slave  (output r_i, a_o, a1_o, input a_i, r_o, r1_o);
endinterface

// File: rtl/hs_sync.sv
// One-bit flop-chain synchroniser; flushed to 0 by synchronous reset.
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/fork_sync.sv
// Clocked four-phase fork: one upstream req/ack channel split to two branches.
module fork_sync
  import async_hs_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  fork_sync_if.master      hs,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  localparam int TO_W = hs_to_w(TIMEOUT);

  logic sr_i, sa0, sa1;
  hs_state_t state;
  logic req_q, ack_q;
  logic hi0, hi1, lo0, lo1;
  logic [TO_W-1:0] wcnt;

  hs_sync #(.STAGES(SYNC_STAGES)) u_sync_r  (.clk(clk), .rst(rst), .d(hs.r_i),  .q(sr_i));
  hs_sync #(.STAGES(SYNC_STAGES)) u_sync_a0 (.clk(clk), .rst(rst), .d(hs.a_o),  .q(sa0));
  hs_sync #(.STAGES(SYNC_STAGES)) u_sync_a1 (.clk(clk), .rst(rst), .d(hs.a1_o), .q(sa1));

  logic hi0_n, hi1_n, lo0_n, lo1_n;
  assign hi0_n = hi0 | sa0;
  assign hi1_n = hi1 | sa1;
  assign lo0_n = lo0 | ~sa0;
  assign lo1_n = lo1 | ~sa1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HS_IDLE;
      req_q <= 1'b0;
      ack_q <= 1'b0;
      hi0   <= 1'b0;
      hi1   <= 1'b0;
      lo0   <= 1'b0;
      lo1   <= 1'b0;
      wcnt  <= '0;
      err   <= 1'b0;
      count <= '0;
    end else begin
      // Wait-state timer advances here; every transition below overrides it back to 0.
      if (state != HS_IDLE && TIMEOUT != 0) begin
        if (wcnt == TO_W'(TIMEOUT)) err <= 1'b1;
        else                        wcnt <= wcnt + 1'b1;
      end

      case (state)
        HS_IDLE: begin
          if (sr_i && !sa0 && !sa1) begin
            state <= HS_RISE;
            req_q <= 1'b1;
            wcnt  <= '0;
          end
        end
        HS_RISE: begin
          hi0 <= hi0_n;
          hi1 <= hi1_n;
          if (!sr_i) err <= 1'b1;
          if (hi0_n && hi1_n) begin
            state <= HS_ACK;
            ack_q <= 1'b1;
            hi0   <= 1'b0;
            hi1   <= 1'b0;
            wcnt  <= '0;
          end
        end
        HS_ACK: begin
          if (!sr_i) begin
            state <= HS_FALL;
            req_q <= 1'b0;
            wcnt  <= '0;
          end
        end
        HS_FALL: begin
          lo0 <= lo0_n;
          lo1 <= lo1_n;
          if (sr_i || (lo0 && sa0) || (lo1 && sa1)) err <= 1'b1;
          if (lo0_n && lo1_n) begin
            state <= HS_IDLE;
            ack_q <= 1'b0;
            lo0   <= 1'b0;
            lo1   <= 1'b0;
            wcnt  <= '0;
            count <= count + 1'b1;
          end
        end
        default: state <= HS_IDLE;
      endcase
    end
  end

  assign hs.r_o  = req_q;
  assign hs.r1_o = req_q;
  assign hs.a_i  = ack_q;
  assign busy    = (state != HS_IDLE);

endmodule

// File: tb/tb_fork_sync.sv
// Directed bench for fork_sync: main instance plus timeout-on/off instances.
module tb_fork_sync;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fork_sync_if hm ();
  fork_sync_if ht ();
  fork_sync_if hz ();

  logic        busy_m, err_m, busy_t, err_t, busy_z, err_z;
  logic [3:0]  count_m;
  logic [15:0] count_t, count_z;

  fork_sync #(.SYNC_STAGES(2), .TIMEOUT(255), .CNT_W(4)) u_main (
    .clk(clk), .rst(rst), .hs(hm), .busy(busy_m), .err(err_m), .count(count_m));
  fork_sync #(.SYNC_STAGES(2), .TIMEOUT(16), .CNT_W(16)) u_to (
    .clk(clk), .rst(rst), .hs(ht), .busy(busy_t), .err(err_t), .count(count_t));
  fork_sync #(.SYNC_STAGES(2), .TIMEOUT(0), .CNT_W(16)) u_off (
    .clk(clk), .rst(rst), .hs(hz), .busy(busy_z), .err(err_z), .count(count_z));

  int checks = 0;
  int failures = 0;

  localparam int S_AI = 0, S_RO = 1, S_R1O = 2, S_BUSY = 3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_m(input int sel);
    case (sel)
      S_AI:    return hm.a_i;
      S_RO:    return hm.r_o;
      S_R1O:   return hm.r1_o;
      default: return busy_m;
    endcase
  endfunction

  task automatic wait_m(input int sel, input logic val, input int budget, input string tag);
    int n = 0;
    while (get_m(sel) !== val && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(get_m(sel)), 32'(val));
  endtask

  task automatic set_acks(input logic v);
    hm.a_o  = v;
    hm.a1_o = v;
  endtask

  initial begin
    rst = 1'b1;
    hm.r_i = 1'b0; hm.a_o = 1'b0; hm.a1_o = 1'b0;
    ht.r_i = 1'b0; ht.a_o = 1'b0; ht.a1_o = 1'b0;
    hz.r_i = 1'b0; hz.a_o = 1'b0; hz.a1_o = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_a_i", 32'(hm.a_i), 0);
    check("rst_r_o", 32'(hm.r_o), 0);
    check("rst_r1_o", 32'(hm.r1_o), 0);
    check("rst_busy", 32'(busy_m), 0);
    check("rst_err", 32'(err_m), 0);
    check("rst_count", 32'(count_m), 0);

    // 1 Basic handshake with exact latencies (2 sync flops + 1 FSM cycle)
    hm.r_i = 1'b1;
    tick(); tick();
    check("basic_r_o_early", 32'(hm.r_o), 0);
    tick();
    check("basic_r_o", 32'(hm.r_o), 1);
    check("basic_r1_o", 32'(hm.r1_o), 1);
    check("basic_busy", 32'(busy_m), 1);
    set_acks(1'b1);
    tick(); tick();
    check("basic_a_i_early", 32'(hm.a_i), 0);
    tick();
    check("basic_a_i_rise", 32'(hm.a_i), 1);
    hm.r_i = 1'b0;
    tick(); tick();
    check("basic_r_o_hold", 32'(hm.r_o), 1);
    tick();
    check("basic_r_o_fall", 32'(hm.r_o), 0);
    check("basic_a_i_hold", 32'(hm.a_i), 1);
    set_acks(1'b0);
    tick(); tick();
    check("basic_a_i_hold2", 32'(hm.a_i), 1);
    tick();
    check("basic_a_i_fall", 32'(hm.a_i), 0);
    check("basic_count", 32'(count_m), 1);
    check("basic_busy_end", 32'(busy_m), 0);
    check("basic_err", 32'(err_m), 0);

    // 2 Skewed branches; branch 0 acks and drops early
    hm.r_i = 1'b1;
    wait_m(S_RO, 1'b1, 8, "skew_r_o");
    tick();
    hm.a_o = 1'b1;
    repeat (3) tick();
    hm.a_o = 1'b0;
    repeat (30) tick();
    check("skew_a_i_wait", 32'(hm.a_i), 0);
    check("skew_err_mid", 32'(err_m), 0);
    hm.a1_o = 1'b1;
    tick(); tick();
    check("skew_a_i_early", 32'(hm.a_i), 0);
    tick();
    check("skew_a_i_rise", 32'(hm.a_i), 1);
    hm.r_i = 1'b0;
    wait_m(S_RO, 1'b0, 8, "skew_r_o_fall");
    hm.a1_o = 1'b0;
    wait_m(S_AI, 1'b0, 8, "skew_a_i_fall");
    check("skew_count", 32'(count_m), 2);
    check("skew_err", 32'(err_m), 0);

    // 3 Upstream withdraws request in RISE
    hm.r_i = 1'b1;
    wait_m(S_RO, 1'b1, 8, "wd_r_o");
    hm.r_i = 1'b0;
    repeat (4) tick();
    check("wd_err", 32'(err_m), 1);
    check("wd_busy", 32'(busy_m), 1);
    check("wd_a_i", 32'(hm.a_i), 0);
    set_acks(1'b1);
    wait_m(S_AI, 1'b1, 8, "wd_a_i_rise");
    wait_m(S_RO, 1'b0, 8, "wd_r_o_fall");
    set_acks(1'b0);
    wait_m(S_AI, 1'b0, 8, "wd_a_i_fall");
    check("wd_count", 32'(count_m), 3);
    check("wd_err_sticky", 32'(err_m), 1);

    // 4 Timeout: branch 1 never acks; TIMEOUT=16 vs TIMEOUT=0
    ht.r_i = 1'b1; hz.r_i = 1'b1;
    repeat (3) tick();
    check("to_r_o", 32'(ht.r_o), 1);
    ht.a_o = 1'b1; hz.a_o = 1'b1;
    repeat (16) tick();
    check("to_err_16", 32'(err_t), 0);
    tick();
    check("to_err_17", 32'(err_t), 1);
    check("to_busy", 32'(busy_t), 1);
    check("to_a_i", 32'(ht.a_i), 0);
    repeat (40) tick();
    check("to_off_err", 32'(err_z), 0);
    check("to_off_busy", 32'(busy_z), 1);

    // 5 Reset while in ACK; acks still high keep the FSM in IDLE
    hm.r_i = 1'b1;
    wait_m(S_RO, 1'b1, 8, "rs_r_o");
    set_acks(1'b1);
    wait_m(S_AI, 1'b1, 8, "rs_a_i");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_a_i_0", 32'(hm.a_i), 0);
    check("rs_r_o_0", 32'(hm.r_o), 0);
    check("rs_busy_0", 32'(busy_m), 0);
    check("rs_err_0", 32'(err_m), 0);
    check("rs_count_0", 32'(count_m), 0);
    repeat (6) tick();
    check("rs_idle_hold", 32'(busy_m), 0);
    check("rs_r_o_hold", 32'(hm.r_o), 0);
    hm.r_i = 1'b0;
    set_acks(1'b0);
    repeat (4) tick();
    hm.r_i = 1'b1;
    wait_m(S_RO, 1'b1, 8, "rs_resume");
    set_acks(1'b1);
    wait_m(S_AI, 1'b1, 8, "rs_resume_a_i");
    hm.r_i = 1'b0;
    wait_m(S_RO, 1'b0, 8, "rs_resume_r_o_fall");
    set_acks(1'b0);
    wait_m(S_AI, 1'b0, 8, "rs_resume_a_i_fall");
    check("rs_count_1", 32'(count_m), 1);

    // 6 Counter wrap with CNT_W=4: 17 reactive back-to-back cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      hm.r_i = 1'b1;
      wait_m(S_RO, 1'b1, 8, "wrap_r_o");
      set_acks(1'b1);
      wait_m(S_AI, 1'b1, 8, "wrap_a_i");
      hm.r_i = 1'b0;
      wait_m(S_RO, 1'b0, 8, "wrap_r_o_fall");
      set_acks(1'b0);
      wait_m(S_AI, 1'b0, 8, "wrap_a_i_fall");
      if (i == 15) check("wrap_count_16", 32'(count_m), 0);
    end
    check("wrap_count", 32'(count_m), 1);
    check("wrap_err", 32'(err_m), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
